// File: rtl/gin_feeder_if.sv
// Signal bundle between gin_feeder and its surroundings: job control, GLB read port and GIN tag/data FIFO push port.
interface gin_feeder_if #(
   parameter int unsigned DATA_WIDTH    = 64,
   parameter int unsigned ROW_TAG_WIDTH = 4,
   parameter int unsigned COL_TAG_WIDTH = 4,
   parameter int unsigned ADDR_WIDTH    = 16,
   parameter int unsigned CNT_WIDTH     = 12
);
   logic                     start;
   logic [ADDR_WIDTH-1:0]    base_addr;
   logic [ROW_TAG_WIDTH-1:0] num_rows;
   logic [COL_TAG_WIDTH-1:0] num_cols;
   logic [CNT_WIDTH-1:0]     words_per_tag;
   logic                     busy;
   logic                     done;
   logic                     glb_rd_en;
   logic [ADDR_WIDTH-1:0]    glb_addr;
   logic [DATA_WIDTH-1:0]    glb_rd_data;
   logic [ROW_TAG_WIDTH-1:0] row_tag;
   logic [COL_TAG_WIDTH-1:0] col_tag;
   logic [DATA_WIDTH-1:0]    data_out;
   logic                     tags_wr_en;
   logic                     data_wr_en;
   logic                     tags_full;
   logic                     data_full;

   modport master (
      input  start, base_addr, num_rows, num_cols, words_per_tag, glb_rd_data, tags_full, data_full,
      output busy, done, glb_rd_en, glb_addr, row_tag, col_tag, data_out, tags_wr_en, data_wr_en
   );

   modport slave (
      output start, base_addr, num_rows, num_cols, words_per_tag, glb_rd_data, tags_full, data_full,
      input  busy, done, glb_rd_en, glb_addr, row_tag, col_tag, data_out, tags_wr_en, data_wr_en
   );
endinterface

// File: rtl/gin_feeder.sv
// GLB-to-GIN block sequencer: walks (row, col, word) order, reads the GLB and pushes each
// word together with its tag into the GIN FIFOs through a 2-entry skid buffer.
module gin_feeder #(
   parameter int unsigned DATA_WIDTH    = 64,
   parameter int unsigned ROW_TAG_WIDTH = 4,
   parameter int unsigned COL_TAG_WIDTH = 4,
   parameter int unsigned ADDR_WIDTH    = 16,
   parameter int unsigned CNT_WIDTH     = 12
) (
   input logic          clk,
   input logic          reset,
   gin_feeder_if.master bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   typedef struct packed {
      logic [DATA_WIDTH-1:0]    data;
      logic [COL_TAG_WIDTH-1:0] col;
      logic [ROW_TAG_WIDTH-1:0] row;
   } skid_entry_t;

   logic [1:0]               state, state_nxt;
   logic [ADDR_WIDTH-1:0]    cfg_base, word_idx;
   logic [ROW_TAG_WIDTH-1:0] cfg_rows, row_cnt, infl_row;
   logic [COL_TAG_WIDTH-1:0] cfg_cols, col_cnt, infl_col;
   logic [CNT_WIDTH-1:0]     cfg_wpt, word_cnt;
   logic                     inflight;
   logic [1:0]               skid_cnt, skid_cnt_nxt;
   skid_entry_t              skid0, skid1, land_entry;
   logic                     cfg_zero, accept, push, issue;
   logic                     row_last, col_last, word_last, last_issue;

   // Datapath decisions; a slot freed by this cycle's push may be refilled by this cycle's read
   always_comb begin
      cfg_zero     = (bus.num_rows == '0) || (bus.num_cols == '0) || (bus.words_per_tag == '0);
      accept       = (state == S_IDLE) && bus.start;
      push         = (skid_cnt != 2'd0) && !bus.tags_full && !bus.data_full;
      skid_cnt_nxt = 2'(skid_cnt + 2'(inflight) - 2'(push));
      issue        = (state == S_RUN) && (skid_cnt_nxt < 2'd2);
      row_last     = ROW_TAG_WIDTH'(row_cnt + 1'b1) == cfg_rows;
      col_last     = COL_TAG_WIDTH'(col_cnt + 1'b1) == cfg_cols;
      word_last    = CNT_WIDTH'(word_cnt + 1'b1) == cfg_wpt;
      last_issue   = issue && row_last && col_last && word_last;
      land_entry   = skid_entry_t'{data: bus.glb_rd_data, col: infl_col, row: infl_row};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next state and outputs
   always_comb begin
      state_nxt      = state;
      bus.busy       = 1'b0;
      bus.done       = 1'b0;
      bus.glb_rd_en  = issue;
      bus.glb_addr   = ADDR_WIDTH'(cfg_base + word_idx);
      bus.tags_wr_en = push;
      bus.data_wr_en = push;
      bus.data_out   = skid0.data;
      bus.col_tag    = skid0.col;
      bus.row_tag    = skid0.row;
      case (state)
         S_IDLE:  if (accept) state_nxt = cfg_zero ? S_DONE : S_RUN;
         S_RUN: begin
            bus.busy = 1'b1;
            if (last_issue) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            bus.busy = 1'b1;
            if (skid_cnt_nxt == 2'd0) state_nxt = S_DONE;
         end
         S_DONE: begin
            bus.done  = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cfg_base <= '0;
         cfg_rows <= '0;
         cfg_cols <= '0;
         cfg_wpt  <= '0;
         row_cnt  <= '0;
         col_cnt  <= '0;
         word_cnt <= '0;
         word_idx <= '0;
         infl_row <= '0;
         infl_col <= '0;
         inflight <= 1'b0;
         skid_cnt <= 2'd0;
         skid0    <= '0;
         skid1    <= '0;
      end else begin
         if (accept) begin
            cfg_base <= bus.base_addr;
            cfg_rows <= bus.num_rows;
            cfg_cols <= bus.num_cols;
            cfg_wpt  <= bus.words_per_tag;
            row_cnt  <= '0;
            col_cnt  <= '0;
            word_cnt <= '0;
            word_idx <= '0;
         end
         // Tag travels with the read request; word is innermost, row outermost
         if (issue) begin
            infl_row <= row_cnt;
            infl_col <= col_cnt;
            word_idx <= word_idx + 1'b1;
            if (word_last) begin
               word_cnt <= '0;
               if (col_last) begin
                  col_cnt <= '0;
                  row_cnt <= row_cnt + 1'b1;
               end else begin
                  col_cnt <= col_cnt + 1'b1;
               end
            end else begin
               word_cnt <= word_cnt + 1'b1;
            end
         end
         inflight <= issue;
         skid_cnt <= skid_cnt_nxt;
         // skid0 is the head; a pop shifts skid1 forward, a landing word fills the first free slot
         if (push && inflight) begin
            if (skid_cnt == 2'd1) begin
               skid0 <= land_entry;
            end else begin
               skid0 <= skid1;
               skid1 <= land_entry;
            end
         end else if (push) begin
            skid0 <= skid1;
         end else if (inflight) begin
            if (skid_cnt == 2'd0) skid0 <= land_entry;
            else                  skid1 <= land_entry;
         end
      end
   end
endmodule

// File: tb/tb_gin_feeder.sv
// Directed bench for gin_feeder: GLB memory model, cycle-by-cycle push capture and an
// expected-order model built from the job configuration.
module tb_gin_feeder;
   localparam int unsigned DW = 64;
   localparam int unsigned RW = 4;
   localparam int unsigned CW = 4;
   localparam int unsigned AW = 16;
   localparam int unsigned NW = 12;

   typedef struct packed {
      logic [DW-1:0] dat;
      logic [CW-1:0] col;
      logic [RW-1:0] row;
   } push_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   gin_feeder_if #(.DATA_WIDTH(DW), .ROW_TAG_WIDTH(RW), .COL_TAG_WIDTH(CW),
                   .ADDR_WIDTH(AW), .CNT_WIDTH(NW)) bus ();

   gin_feeder #(.DATA_WIDTH(DW), .ROW_TAG_WIDTH(RW), .COL_TAG_WIDTH(CW),
                .ADDR_WIDTH(AW), .CNT_WIDTH(NW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   function automatic logic [DW-1:0] glb_word(input logic [AW-1:0] a);
      return {16'hD00D, a, ~a, a ^ 16'h5A5A};
   endfunction

   // GLB SRAM: data valid the cycle after the read request
   always @(posedge clk) if (bus.glb_rd_en) bus.glb_rd_data <= glb_word(bus.glb_addr);

   int total = 0;
   int bad   = 0;
   push_t         got_q[$];
   push_t         exp_q[$];
   logic [AW-1:0] addr_q[$];
   logic [AW-1:0] exp_addr[$];
   int cyc_n, first_rd, first_push, last_push, done_cyc, done_cnt, busy_cnt, rd_cnt, stall_rd;
   int stall_lo = 1;
   int stall_hi = 0;
   bit rnd_full = 1'b0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive full flags, sample mid-cycle, advance to just after the next edge
   task automatic cyc();
      bus.data_full = (cyc_n >= stall_lo) && (cyc_n <= stall_hi);
      bus.tags_full = 1'b0;
      if (rnd_full) begin
         bus.tags_full = ($urandom_range(0, 2) == 0);
         bus.data_full = ($urandom_range(0, 2) == 0);
      end
      #3;
      if (bus.tags_wr_en || bus.data_wr_en) begin
         check("wr_en_pair", 128'(bus.tags_wr_en), 128'(bus.data_wr_en));
         check("push_while_full", 128'({bus.tags_full, bus.data_full}), 128'(2'b00));
         got_q.push_back({bus.data_out, bus.col_tag, bus.row_tag});
         if (first_push < 0) first_push = cyc_n;
         last_push = cyc_n;
      end
      if (bus.glb_rd_en) begin
         addr_q.push_back(bus.glb_addr);
         if (first_rd < 0) first_rd = cyc_n;
         rd_cnt++;
         if (bus.data_full) stall_rd++;
      end
      if (bus.done) begin
         done_cnt++;
         done_cyc = cyc_n;
      end
      if (bus.busy) busy_cnt++;
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   task automatic start_job(input logic [AW-1:0] base, input int rows, input int cols, input int wpt);
      got_q.delete();
      addr_q.delete();
      cyc_n = 0; first_rd = -1; first_push = -1; last_push = -1; done_cyc = -1;
      done_cnt = 0; busy_cnt = 0; rd_cnt = 0; stall_rd = 0;
      bus.base_addr     = base;
      bus.num_rows      = RW'(rows);
      bus.num_cols      = CW'(cols);
      bus.words_per_tag = NW'(wpt);
      bus.start         = 1'b1;
      cyc();
      bus.start = 1'b0;
   endtask

   task automatic run_to_done(input int budget);
      while (done_cnt == 0 && cyc_n < budget) cyc();
      check("done_seen", 128'(done_cnt), 128'(1));
      repeat (3) cyc();
      check("done_single_pulse", 128'(done_cnt), 128'(1));
   endtask

   task automatic build_exp(input logic [AW-1:0] base, input int rows, input int cols, input int wpt);
      int idx;
      logic [AW-1:0] a;
      exp_q.delete();
      exp_addr.delete();
      idx = 0;
      for (int ri = 0; ri < rows; ri++)
         for (int ci = 0; ci < cols; ci++)
            for (int wi = 0; wi < wpt; wi++) begin
               a = AW'(base + AW'(idx));
               exp_q.push_back(push_t'{dat: glb_word(a), col: CW'(ci), row: RW'(ri)});
               exp_addr.push_back(a);
               idx++;
            end
   endtask

   task automatic compare_job(input string tag);
      check({tag, "_push_count"}, 128'(got_q.size()), 128'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("%s_push%0d", tag, i), 128'(got_q[i]), 128'(exp_q[i]));
      check({tag, "_read_count"}, 128'(addr_q.size()), 128'(exp_addr.size()));
      for (int i = 0; i < exp_addr.size() && i < addr_q.size(); i++)
         check($sformatf("%s_addr%0d", tag, i), 128'(addr_q[i]), 128'(exp_addr[i]));
   endtask

   initial begin
      bus.start = 1'b0; bus.base_addr = '0; bus.num_rows = '0; bus.num_cols = '0;
      bus.words_per_tag = '0; bus.tags_full = 1'b0; bus.data_full = 1'b0;
      cyc_n = 0; first_rd = -1; first_push = -1; last_push = -1; done_cyc = -1;
      done_cnt = 0; busy_cnt = 0; rd_cnt = 0; stall_rd = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 128'(bus.busy), 128'(0));
      check("rst_done", 128'(bus.done), 128'(0));
      check("rst_rd_en", 128'(bus.glb_rd_en), 128'(0));
      check("rst_wr_en", 128'({bus.tags_wr_en, bus.data_wr_en}), 128'(0));
      check("rst_addr", 128'(bus.glb_addr), 128'(0));
      check("rst_data", 128'(bus.data_out), 128'(0));
      reset = 1'b1;
      @(posedge clk);
      #1;

      // 2x3x1 block, no back-pressure
      start_job(16'h0010, 2, 3, 1);
      run_to_done(100);
      build_exp(16'h0010, 2, 3, 1);
      compare_job("t1");
      check("t1_first_read_cycle", 128'(first_rd), 128'(1));
      check("t1_first_push_latency", 128'(first_push - first_rd), 128'(2));
      check("t1_back_to_back", 128'(last_push - first_push), 128'(5));
      check("t1_done_after_last", 128'(done_cyc), 128'(last_push + 1));
      check("t1_busy_cycles", 128'(busy_cnt), 128'(done_cyc - 1));

      // data FIFO full in cycles 3..7
      stall_lo = 3; stall_hi = 7;
      start_job(16'h0200, 1, 1, 4);
      run_to_done(100);
      stall_lo = 1; stall_hi = 0;
      build_exp(16'h0200, 1, 1, 4);
      compare_job("t2");
      check("t2_no_read_in_stall", 128'(stall_rd), 128'(0));
      check("t2_first_push_after_stall", 128'(first_push), 128'(8));
      check("t2_done_after_last", 128'(done_cyc), 128'(last_push + 1));

      // address wrap
      start_job(16'hFFFE, 1, 1, 4);
      run_to_done(100);
      build_exp(16'hFFFE, 1, 1, 4);
      compare_job("t3");
      check("t3_addr2_wrapped", 128'(addr_q.size() > 2 ? addr_q[2] : 16'hDEAD), 128'(16'h0000));

      // zero words per tag
      start_job(16'h0010, 1, 1, 0);
      run_to_done(20);
      check("t4_done_cycle", 128'(done_cyc), 128'(1));
      check("t4_reads", 128'(rd_cnt), 128'(0));
      check("t4_pushes", 128'(got_q.size()), 128'(0));
      check("t4_busy", 128'(busy_cnt), 128'(0));

      // start while busy with different config is ignored
      start_job(16'h0100, 2, 2, 2);
      repeat (3) cyc();
      bus.base_addr = 16'h0BAD; bus.num_rows = RW'(1); bus.num_cols = CW'(1); bus.words_per_tag = NW'(1);
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      run_to_done(200);
      build_exp(16'h0100, 2, 2, 2);
      compare_job("t5a");

      // reset mid-run
      start_job(16'h0300, 2, 2, 2);
      repeat (3) cyc();
      #2 reset = 1'b0;
      #1;
      check("t5_abort_busy", 128'(bus.busy), 128'(0));
      check("t5_abort_rd_en", 128'(bus.glb_rd_en), 128'(0));
      check("t5_abort_wr_en", 128'({bus.tags_wr_en, bus.data_wr_en}), 128'(0));
      check("t5_abort_addr", 128'(bus.glb_addr), 128'(0));
      check("t5_abort_done", 128'(bus.done), 128'(0));
      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (5) cyc();
      check("t5_no_done_after_abort", 128'(done_cnt), 128'(0));
      check("t5_idle_after_abort", 128'(bus.busy), 128'(0));
      start_job(16'h0040, 1, 2, 3);
      run_to_done(100);
      build_exp(16'h0040, 1, 2, 3);
      compare_job("t5b");

      // random back-pressure on both FIFOs
      rnd_full = 1'b1;
      start_job(16'h2000, 3, 4, 5);
      run_to_done(2000);
      rnd_full = 1'b0;
      build_exp(16'h2000, 3, 4, 5);
      compare_job("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
